// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared register-file geometry (register count, data width, zero-register index).
package wb_regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_regfile_gpr_array.sv
// gpr_array: 32x32 general-purpose register storage with one write port and two combinational read ports.
module gpr_array
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_a_addr_i,
    input  logic [ADDR_W-1:0] rd_b_addr_i,
    output logic [DATA_W-1:0] rd_a_data_o,
    output logic [DATA_W-1:0] rd_b_data_o
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_en_i && wr_addr_i != ZERO_REG) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The zero register is hard-wired so it reads 0 even before the first reset.
    assign rd_a_data_o = (rd_a_addr_i == ZERO_REG) ? '0 : regs_q[rd_a_addr_i];
    assign rd_b_data_o = (rd_b_addr_i == ZERO_REG) ? '0 : regs_q[rd_b_addr_i];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, register file and retired-write counter.
// Define WB_BYPASS_EN to forward the same-cycle writeback value onto the read ports.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_busC,
    input  logic [DATA_W-1:0] i_out,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic              i_GPRWR,
    input  logic              i_MTR,
    input  logic [ADDR_W-1:0] i_rs,
    input  logic [ADDR_W-1:0] i_rt,
    output logic [DATA_W-1:0] o_busA,
    output logic [DATA_W-1:0] o_busB,
    output logic [DATA_W-1:0] o_wbdata,
    output logic [DATA_W-1:0] o_wbcnt
);
    logic              wr_en;
    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_b_data;
    logic [DATA_W-1:0] wbcnt_q;
    logic [DATA_W-1:0] wbcnt_d;

    assign o_wbdata = i_MTR ? i_out : i_busC;
    assign wr_en    = rst_n && i_GPRWR && i_rd != ZERO_REG;
    assign wbcnt_d  = wr_en ? wbcnt_q + 1'b1 : wbcnt_q;

    gpr_array u_gpr (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (wr_en),
        .wr_addr_i   (i_rd),
        .wr_data_i   (o_wbdata),
        .rd_a_addr_i (i_rs),
        .rd_b_addr_i (i_rt),
        .rd_a_data_o (rd_a_data),
        .rd_b_data_o (rd_b_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) wbcnt_q <= '0;
        else        wbcnt_q <= wbcnt_d;
    end

    assign o_wbcnt = wbcnt_q;

`ifdef WB_BYPASS_EN
    assign o_busA = (wr_en && i_rd == i_rs) ? o_wbdata : rd_a_data;
    assign o_busB = (wr_en && i_rd == i_rt) ? o_wbdata : rd_b_data;
`else
    assign o_busA = rd_a_data;
    assign o_busB = rd_b_data;
`endif
endmodule
